// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, instruction field bit positions, the default
// HALT opcode, the IF/ID register layout and its bubble value.
package fetch_pkg;

    // FSM state encoding (plain constants so legacy tools can consume them)
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 28;
    localparam int RG_HI    = 27;
    localparam int RG_LO    = 24;
    localparam int RP_HI    = 23;
    localparam int RP_LO    = 20;
    localparam int RS_HI    = 19;
    localparam int RS_LO    = 16;
    localparam int IMM16_HI = 15;
    localparam int IMM24_HI = 23;

    localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;
    localparam logic [31:0] BUBBLE_INSTR    = 32'h0000_0000;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic        valid;
        logic [31:0] pcp4;
        logic [31:0] instr;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pcp4: 32'h0, instr: BUBBLE_INSTR};

    // Sequential fetch address; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Branch targets are word aligned; the low two bits are discarded
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running fetch statistics (fetched words, stall cycles,
// accepted redirects). Each counter is cleared by rst and wraps at 2^32.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_fetch_i,
    input  logic        inc_stall_i,
    input  logic        inc_flush_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);

    logic [31:0] fetched_q, stall_q, flush_q;

    // Event counters, one increment per qualifying cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= 32'h0;
            stall_q   <= 32'h0;
            flush_q   <= 32'h0;
        end else begin
            if (inc_fetch_i) fetched_q <= fetched_q + 32'd1;
            if (inc_stall_i) stall_q   <= stall_q + 32'd1;
            if (inc_flush_i) flush_q   <= flush_q + 32'd1;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_stall_o   = stall_q;
    assign perf_flush_o   = flush_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the image-filter pipeline. Owns the PC,
// addresses the synchronous instruction ROM and holds the IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_stall/
// perf_flush counter outputs (fetch_perf_cnt).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] PCmas4_Out,
    output logic [31:0] instr_out,
    output logic [3:0]  opcode,
    output logic [3:0]  Rg_Out,
    output logic [3:0]  Rp,
    output logic [3:0]  Rs,
    output logic [15:0] imm16,
    output logic [23:0] imm24,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;

    logic [31:0] target;
    logic [31:0] pc_seq;
    logic        rdata_is_halt;

    assign target        = align_word(branch_target);
    assign pc_seq        = pc_plus4(pc_q);
    assign rdata_is_halt = (imem_rdata[OPC_HI:OPC_LO] == HALT_OP);

    // Next-state and ROM address: pc_q always names the word on imem_rdata,
    // so whatever address is presented here becomes pc_d.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ifid_d    = ifid_q;
        imem_addr = pc_q;

        case (state_q)
            ST_BOOT: begin
                imem_addr = RESET_PC;
                pc_d      = RESET_PC;
                state_d   = ST_RUN;
            end

            ST_RUN: begin
                if (branch_taken) begin
                    imem_addr = target;
                    pc_d      = target;
                    ifid_d    = IFID_BUBBLE;
                end else if (!stall) begin
                    ifid_d = '{valid: 1'b1, pcp4: pc_seq, instr: imem_rdata};
                    if (rdata_is_halt) begin
                        // Stop here: keep re-reading the halt word's address
                        state_d = ST_HALT;
                    end else begin
                        imem_addr = pc_seq;
                        pc_d      = pc_seq;
                    end
                end
            end

            ST_HALT: begin
                // An older branch still in Execute overrides the halt
                if (branch_taken) begin
                    imem_addr = target;
                    pc_d      = target;
                    ifid_d    = IFID_BUBBLE;
                    state_d   = ST_RUN;
                end else if (!stall) begin
                    ifid_d = IFID_BUBBLE;
                end
            end

            default: begin
                imem_addr = RESET_PC;
                pc_d      = RESET_PC;
                ifid_d    = IFID_BUBBLE;
                state_d   = ST_BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= IFID_BUBBLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign valid_out  = ifid_q.valid;
    assign PCmas4_Out = ifid_q.pcp4;
    assign instr_out  = ifid_q.instr;
    assign opcode     = ifid_q.instr[OPC_HI:OPC_LO];
    assign Rg_Out     = ifid_q.instr[RG_HI:RG_LO];
    assign Rp         = ifid_q.instr[RP_HI:RP_LO];
    assign Rs         = ifid_q.instr[RS_HI:RS_LO];
    assign imm16      = ifid_q.instr[IMM16_HI:0];
    assign imm24      = ifid_q.instr[IMM24_HI:0];
    assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic ev_fetch, ev_stall, ev_flush;

    assign ev_fetch = (state_q == ST_RUN) && !branch_taken && !stall;
    assign ev_stall = (state_q == ST_RUN) && !branch_taken && stall;
    assign ev_flush = ((state_q == ST_RUN) || (state_q == ST_HALT)) && branch_taken;

    fetch_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .inc_fetch_i    (ev_fetch),
        .inc_stall_i    (ev_stall),
        .inc_flush_i    (ev_flush),
        .perf_fetched_o (perf_fetched),
        .perf_stall_o   (perf_stall),
        .perf_flush_o   (perf_flush)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a
// behavioural synchronous ROM. Perf counter checks run when
// FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] PCmas4_Out;
    logic [31:0] instr_out;
    logic [3:0]  opcode, Rg_Out, Rp, Rs;
    logic [15:0] imm16;
    logic [23:0] imm24;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .valid_out     (valid_out),
        .PCmas4_Out    (PCmas4_Out),
        .instr_out     (instr_out),
        .opcode        (opcode),
        .Rg_Out        (Rg_Out),
        .Rp            (Rp),
        .Rs            (Rs),
        .imm16         (imm16),
        .imm24         (imm24),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
`endif
    );

    // ROM contents: a HALT word at 0x20, otherwise 0x1234 followed by addr[15:0]
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h20) return 32'hF000_0020;
        return 32'h1234_0000 | {16'h0, a[15:0]};
    endfunction

    always @(posedge clk) imem_rdata <= rom(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic s, input logic b, input logic [31:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set(1'b0, 1'b0, 32'h0);
        repeat (2) tick();

        // Reset state
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pcp4",  PCmas4_Out, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);

        // Boot edge, then sequential fetch
        rst = 1'b0;
        tick();
        check("boot_valid", {31'h0, valid_out}, 32'h0);
        check("boot_addr",  imem_addr, 32'h4);
        tick();
        check("seq0_valid", {31'h0, valid_out}, 32'h1);
        check("seq0_pcp4",  PCmas4_Out, 32'h4);
        check("seq0_instr", instr_out, 32'h1234_0000);
        check("seq0_addr",  imem_addr, 32'h8);
        tick();
        check("seq1_pcp4",  PCmas4_Out, 32'h8);
        check("seq1_instr", instr_out, 32'h1234_0004);
        check("fld_opcode", {28'h0, opcode}, 32'h1);
        check("fld_rg",     {28'h0, Rg_Out}, 32'h2);
        check("fld_rp",     {28'h0, Rp}, 32'h3);
        check("fld_rs",     {28'h0, Rs}, 32'h4);
        check("fld_imm16",  {16'h0, imm16}, 32'h0004);
        check("fld_imm24",  {8'h0, imm24}, 32'h34_0004);
        tick();
        check("seq2_pcp4",  PCmas4_Out, 32'hC);
        check("seq2_instr", instr_out, 32'h1234_0008);

        // Three stall cycles: everything frozen, ROM re-reads pc
        set(1'b1, 1'b0, 32'h0);
        check("stall_addr", imem_addr, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'h0, valid_out}, 32'h1);
            check("stall_pcp4",  PCmas4_Out, 32'hC);
            check("stall_instr", instr_out, 32'h1234_0008);
            check("stall_hold_addr", imem_addr, 32'hC);
        end
        set(1'b0, 1'b0, 32'h0);
        check("resume_addr", imem_addr, 32'h10);
        tick();
        check("resume_pcp4",  PCmas4_Out, 32'h10);
        check("resume_instr", instr_out, 32'h1234_000C);

        // Branch to 0x100
        set(1'b0, 1'b1, 32'h100);
        check("br_addr", imem_addr, 32'h100);
        tick();
        check("br_bubble", {31'h0, valid_out}, 32'h0);
        set(1'b0, 1'b0, 32'h0);
        tick();
        check("br_valid", {31'h0, valid_out}, 32'h1);
        check("br_pcp4",  PCmas4_Out, 32'h104);
        check("br_instr", instr_out, 32'h1234_0100);

        // Branch and stall together; low target bits discarded
        set(1'b1, 1'b1, 32'h203);
        check("brst_addr", imem_addr, 32'h200);
        tick();
        check("brst_bubble", {31'h0, valid_out}, 32'h0);
        set(1'b0, 1'b0, 32'h0);
        tick();
        check("brst_pcp4",  PCmas4_Out, 32'h204);
        check("brst_instr", instr_out, 32'h1234_0200);

        // Run into the HALT word at 0x20
        set(1'b0, 1'b1, 32'h18);
        tick();
        set(1'b0, 1'b0, 32'h0);
        tick();
        check("pre_halt_pcp4", PCmas4_Out, 32'h1C);
        tick();
        check("pre_halt_instr", instr_out, 32'h1234_001C);
        check("pre_halt_addr",  imem_addr, 32'h20);
        check("pre_halt_halted", {31'h0, halted}, 32'h0);
        tick();
        check("halt_valid",  {31'h0, valid_out}, 32'h1);
        check("halt_instr",  instr_out, 32'hF000_0020);
        check("halt_pcp4",   PCmas4_Out, 32'h24);
        check("halt_opcode", {28'h0, opcode}, 32'hF);
        check("halt_flag",   {31'h0, halted}, 32'h1);
        check("halt_addr",   imem_addr, 32'h20);
        tick();
        check("halt_bubble", {31'h0, valid_out}, 32'h0);
        check("halt_flag2",  {31'h0, halted}, 32'h1);
        set(1'b1, 1'b0, 32'h0);
        tick();
        check("halt_stall_valid", {31'h0, valid_out}, 32'h0);
        check("halt_stall_flag",  {31'h0, halted}, 32'h1);
        check("halt_stall_addr",  imem_addr, 32'h20);

        // Branch out of HALT
        set(1'b0, 1'b1, 32'h40);
        tick();
        check("unhalt_flag",  {31'h0, halted}, 32'h0);
        check("unhalt_valid", {31'h0, valid_out}, 32'h0);
        set(1'b0, 1'b0, 32'h0);
        tick();
        check("unhalt_pcp4",  PCmas4_Out, 32'h44);
        check("unhalt_instr", instr_out, 32'h1234_0040);

        // PC wrap at the top of the address space
        set(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        set(1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        tick();
        check("wrap_pcp4",  PCmas4_Out, 32'h0);
        check("wrap_instr", instr_out, 32'h1234_FFFC);
        check("wrap_addr2", imem_addr, 32'h4);
        tick();
        check("wrap_next_pcp4",  PCmas4_Out, 32'h4);
        check("wrap_next_instr", instr_out, 32'h1234_0000);

`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd12);
        check("perf_stall",   perf_stall, 32'd3);
        check("perf_flush",   perf_flush, 32'd5);
`endif

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        check("mrst_valid", {31'h0, valid_out}, 32'h0);
        check("mrst_instr", instr_out, 32'h0);
        check("mrst_pcp4",  PCmas4_Out, 32'h0);
        check("mrst_addr",  imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("mrst_perf_fetched", perf_fetched, 32'd0);
        check("mrst_perf_flush",   perf_flush, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("mrst_boot_valid", {31'h0, valid_out}, 32'h0);
        tick();
        check("mrst_first_valid", {31'h0, valid_out}, 32'h1);
        check("mrst_first_pcp4",  PCmas4_Out, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
